// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// The SCAN_BLANK_EN macro, used by display_scan, selects inter-digit blanking.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
    } frame_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}, indexed by hex value (entry 0 is the LSB slice)
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/display_scan_hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = SEG_TABLE[i_hex];

endmodule

// File: rtl/display_scan.sv
// Eight-digit 7-segment scanner with double-buffered, tear-free updates.
// Define SCAN_BLANK_EN to insert BLANK_CYC dark cycles between digits.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic [2:0]  sel,
    output logic        g,
    output logic        g2a,
    output logic        g2b,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic        upd_ack,
    output logic        frame_done
);

    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam bit          PARAMS_OK = (PRESCALE >= 2) && (PRESCALE <= 65535) &&
                                        (BLANK_CYC >= 1) && (BLANK_CYC <= 255);
`ifdef SCAN_BLANK_EN
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYC - 1);
`endif

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [15:0] r_pcnt;
`ifdef SCAN_BLANK_EN
    logic [7:0]  r_bcnt;
`endif
    frame_t      r_shadow;
    frame_t      r_disp;
    logic        r_pending;

    state_t      w_state_nxt;
    logic [2:0]  w_sel_nxt;
    logic        w_wrap;
    logic        w_commit;
    logic        w_entry;
    logic        w_g_nxt;
    logic        w_en;
    frame_t      w_disp_nxt;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg_c;

    // Out-of-range parameters keep the display dark rather than misbehave
    assign w_en = en & PARAMS_OK;

    // Next-state, digit advance and commit decision
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) begin
                    w_state_nxt = SHOW;
                    w_sel_nxt   = 3'd0;
                end
            end
            SHOW: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 3'd0;
                end else if (r_pcnt == PRE_LAST) begin
`ifdef SCAN_BLANK_EN
                    w_state_nxt = BLANK;
`else
                    w_sel_nxt   = r_sel + 3'd1;
                    w_wrap      = (r_sel == 3'd7);
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 3'd0;
                end else if (r_bcnt == BLANK_LAST) begin
                    w_state_nxt = SHOW;
                    w_sel_nxt   = r_sel + 3'd1;
                    w_wrap      = (r_sel == 3'd7);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 3'd0;
            end
        endcase
    end

    // Shadow reaches the display only between frames or while idle
    assign w_commit   = r_pending & ((r_state == IDLE) | w_wrap);
    assign w_entry    = (w_state_nxt != r_state) | (w_sel_nxt != r_sel);
    assign w_g_nxt    = (w_state_nxt == SHOW);
    assign w_disp_nxt = w_commit ? r_shadow : r_disp;
    assign w_nib      = w_disp_nxt.data[{w_sel_nxt, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_hex   (w_nib),
        .o_seg_c (w_seg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= 3'd0;
            r_pcnt     <= 16'd0;
`ifdef SCAN_BLANK_EN
            r_bcnt     <= 8'd0;
`endif
            r_shadow   <= '0;
            r_disp     <= '0;
            r_pending  <= 1'b0;
            sel        <= 3'd0;
            g          <= 1'b0;
            g2a        <= 1'b0;
            g2b        <= 1'b0;
            seg        <= SEG_OFF;
            seg_dp     <= 1'b1;
            upd_ack    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_pcnt  <= (w_entry || w_state_nxt != SHOW) ? 16'd0 : r_pcnt + 16'd1;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= (w_entry || w_state_nxt != BLANK) ? 8'd0 : r_bcnt + 8'd1;
`endif
            // A load landing on a commit cycle stays pending for the next point
            if (load) begin
                r_shadow.data <= data;
                r_shadow.dp   <= dp;
            end
            r_pending  <= load | (r_pending & ~w_commit);
            r_disp     <= w_disp_nxt;

            sel        <= w_sel_nxt;
            g          <= w_g_nxt;
            g2a        <= 1'b0;
            g2b        <= 1'b0;
            seg        <= w_g_nxt ? w_seg_c : SEG_OFF;
            seg_dp     <= w_g_nxt ? ~w_disp_nxt.dp[w_sel_nxt] : 1'b1;
            upd_ack    <= w_commit;
            frame_done <= w_wrap;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed, table-driven bench for display_scan (PRESCALE=4, BLANK_CYC=2).
`timescale 1ns/1ps
module tb_display_scan;

    localparam int unsigned PRE = 4;
    localparam int unsigned BCY = 2;
`ifdef SCAN_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int DIGP    = PRE + BLK;
    localparam int FR      = 8 * DIGP;
    localparam int DROP_PH = (BLK > 0) ? PRE : 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [31:0] data  = 32'd0;
    logic [7:0]  dp    = 8'd0;
    logic [2:0]  sel;
    logic        g, g2a, g2b;
    logic [6:0]  seg;
    logic        seg_dp, upd_ack, frame_done;

    display_scan #(.PRESCALE(PRE), .BLANK_CYC(BCY)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp),
        .sel(sel), .g(g), .g2a(g2a), .g2b(g2b), .seg(seg), .seg_dp(seg_dp),
        .upd_ack(upd_ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     data;
        logic [7:0]      dp;
        logic [7:0][6:0] seg;   // expected pattern per digit, index = sel
        logic [7:0]      dpn;   // expected active-low seg_dp per digit
    } fvec_t;

    fvec_t vec [4];

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int cur   = 0;
    int pend  = -1;
    int nrec  = 0;
    int ld_a_off = -1;
    int ld_b_off = -1;
    int drop_t   = -1;

    function automatic logic [15:0] outs();
        return {g, g2a, g2b, sel, seg, seg_dp, upd_ack, frame_done};
    endfunction

    function automatic logic [15:0] pack(input logic gx, input logic [2:0] s, input logic [6:0] sg,
                                         input logic sd, input logic a, input logic f);
        return {gx, 1'b0, 1'b0, s, sg, sd, a, f};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got={g,g2a,g2b,sel,seg,dp,ack,fd}=%h expected=%h", name, t, got, exp);
        end
    endtask

    // One scan cycle: check outputs against the frame model, then drive next inputs
    task automatic scan_cycle();
        int ph, d;
        logic gx, ackx, fdx;
        @(negedge clk);
        ph   = (t % FR) % DIGP;
        d    = (t % FR) / DIGP;
        fdx  = (t > 0) && (t % FR == 0);
        ackx = 1'b0;
        if (fdx && pend >= 0) begin
            ackx = 1'b1;
            cur  = pend;
            pend = -1;
        end
        gx = (ph < PRE);
        chk("scan", outs(), pack(gx, 3'(d), gx ? vec[cur].seg[3'(d)] : 7'h7F,
                                 gx ? vec[cur].dpn[3'(d)] : 1'b1, ackx, fdx));
        load = 1'b0;
        if (t % FR == ld_a_off) begin
            load = 1'b1; data = 32'h11111111; dp = 8'hFF;
        end
        if (t % FR == ld_b_off) begin
            load = 1'b1; data = vec[nrec].data; dp = vec[nrec].dp;
            pend = nrec; ld_a_off = -1; ld_b_off = -1;
        end
        if (t == drop_t) en = 1'b0;
        t++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        vec[0].data = 32'h76543210; vec[0].dp = 8'h81; vec[0].dpn = 8'h7E;
        vec[0].seg  = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        vec[1].data = 32'hFFFFFFFF; vec[1].dp = 8'h00; vec[1].dpn = 8'hFF;
        vec[1].seg  = {8{7'h0E}};
        vec[2].data = 32'hFEDCBA98; vec[2].dp = 8'h5A; vec[2].dpn = 8'hA5;
        vec[2].seg  = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        vec[3].data = 32'h0;        vec[3].dp = 8'h00; vec[3].dpn = 8'hFF;
        vec[3].seg  = {8{7'h40}};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_quiet", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));

        // Two back-to-back idle loads: the second lands on the commit cycle and is deferred
        load = 1'b1; data = vec[1].data; dp = vec[1].dp;
        @(negedge clk);
        chk("idle_ack_none", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));
        data = vec[0].data; dp = vec[0].dp;
        @(negedge clk);
        chk("idle_ack_first", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b1, 1'b0));
        load = 1'b0;
        @(negedge clk);
        chk("idle_ack_deferred", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b1, 1'b0));

        en = 1'b1; t = 0; cur = 0; pend = -1;
        nrec = 1; ld_b_off = 3 * DIGP;
        repeat (FR) scan_cycle();
        nrec = 2; ld_a_off = DIGP; ld_b_off = 5 * DIGP;
        repeat (FR) scan_cycle();
        drop_t = 3 * FR + 5 * DIGP + DROP_PH;
        while (t <= drop_t) scan_cycle();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_drop_idle", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));
        end

        en = 1'b1; t = 0; drop_t = -1;
        repeat (FR + 2) scan_cycle();

        // Asynchronous reset between clock edges, mid-SHOW
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("reset_held", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_quiet2", outs(), pack(1'b0, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0));

        en = 1'b1; t = 0; cur = 3; pend = -1; ld_a_off = -1; ld_b_off = -1;
        repeat (FR) scan_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
